// File: rtl/ram_sp_param_if.sv
// Request/response bundle for the single-port RAM with byte enables.
// The master issues requests; the slave (the RAM) returns read data and status.
interface ram_sp_param_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
);
    logic                  write_enable;
    logic                  read_enable;
    logic [ADDR_W-1:0]     address;
    logic [DATA_W-1:0]     data_in;
    logic [DATA_W/8-1:0]   byte_en;
    logic [DATA_W-1:0]     data_out;
    logic                  data_valid;
    logic                  busy;
    logic                  err;

    modport master (
        output write_enable,
        output read_enable,
        output address,
        output data_in,
        output byte_en,
        input  data_out,
        input  data_valid,
        input  busy,
        input  err
    );

    modport slave (
        input  write_enable,
        input  read_enable,
        input  address,
        input  data_in,
        input  byte_en,
        output data_out,
        output data_valid,
        output busy,
        output err
    );
endinterface

// File: rtl/ram_sp_param.sv
// Single-port RAM with per-byte write mask, registered read and a post-reset
// clear sequence that fills every word with INIT_VAL before accepting requests.
module ram_sp_param #(
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 5,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic          clk,
    input  logic          reset,
    ram_sp_param_if.slave bus
);
    localparam int                NUM_BYTES = DATA_W / 8;
    localparam int                DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    if ((DATA_W % 8) != 0) begin : g_bad_width
        $error("ram_sp_param: DATA_W must be a multiple of 8");
    end

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    state_t              state_reg;
    logic [ADDR_W-1:0]   clr_cnt_reg;
    logic                busy_reg;
    logic                data_valid_reg;
    logic                err_reg;

    logic                    we;
    logic                    re;
    logic [ADDR_W-1:0]       addr;
    logic [DATA_W-1:0]       wdata;
    logic [NUM_BYTES-1:0]    be;
    logic [DATA_W-1:0]       rd_data;

    logic                    clear_we;
    logic                    wr_fire;
    logic                    rd_fire;
    logic                    conflict;

    assign we    = bus.write_enable;
    assign re    = bus.read_enable;
    assign addr  = bus.address;
    assign wdata = bus.data_in;
    assign be    = bus.byte_en;

    // Requests only count in IDLE; a simultaneous read+write is rejected.
    assign clear_we = (state_reg == CLEAR);
    assign wr_fire  = (state_reg == IDLE) && we && !re;
    assign rd_fire  = (state_reg == IDLE) && re && !we;
    assign conflict = (state_reg == IDLE) && we && re;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= CLEAR;
            clr_cnt_reg    <= '0;
            busy_reg       <= 1'b1;
            data_valid_reg <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            data_valid_reg <= 1'b0;
            err_reg        <= 1'b0;
            case (state_reg)
                CLEAR: begin
                    clr_cnt_reg <= clr_cnt_reg + 1'b1;
                    if (clr_cnt_reg == LAST_ADDR) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                IDLE: begin
                    data_valid_reg <= rd_fire;
                    err_reg        <= conflict;
                end
                default: begin
                    state_reg   <= CLEAR;
                    clr_cnt_reg <= '0;
                    busy_reg    <= 1'b1;
                end
            endcase
        end
    end

    // One narrow array per byte lane keeps the byte mask a plain write enable,
    // so each lane maps onto its own block RAM column.
    for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_lane
        logic [7:0] mem_lane [DEPTH];
        logic [7:0] q_reg;

        always_ff @(posedge clk) begin
            if (clear_we) begin
                mem_lane[clr_cnt_reg] <= INIT_VAL[8*gi +: 8];
            end else if (wr_fire && be[gi]) begin
                mem_lane[addr] <= wdata[8*gi +: 8];
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                q_reg <= '0;
            end else if (rd_fire) begin
                q_reg <= mem_lane[addr];
            end
        end

        assign rd_data[8*gi +: 8] = q_reg;
    end

    assign bus.data_out   = rd_data;
    assign bus.data_valid = data_valid_reg;
    assign bus.busy       = busy_reg;
    assign bus.err        = err_reg;

endmodule

// File: tb/tb_ram_sp_param.sv
// Directed + random check of ram_sp_param: an 8-bit/32-word instance and a
// 16-bit/8-word instance with a non-zero INIT_VAL, against array models.
module tb_ram_sp_param;
    logic clk;
    logic reset;

    int checks = 0;
    int errors = 0;

    ram_sp_param_if #(.DATA_W(8),  .ADDR_W(5)) a_if ();
    ram_sp_param_if #(.DATA_W(16), .ADDR_W(3)) b_if ();

    ram_sp_param #(.DATA_W(8), .ADDR_W(5), .INIT_VAL(8'h00)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (a_if.slave)
    );

    ram_sp_param #(.DATA_W(16), .ADDR_W(3), .INIT_VAL(16'hBEEF)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (b_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  mdl_a [32];
    logic [15:0] mdl_b [8];
    logic [7:0]  exp_q_a;
    logic [15:0] exp_q_b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_models();
        for (int i = 0; i < 32; i++) mdl_a[i] = 8'h00;
        for (int i = 0; i < 8; i++)  mdl_b[i] = 16'hBEEF;
        exp_q_a = 8'h00;
        exp_q_b = 16'h0000;
    endtask

    task automatic idle_inputs();
        a_if.write_enable = 0; a_if.read_enable = 0; a_if.address = '0; a_if.data_in = '0; a_if.byte_en = '0;
        b_if.write_enable = 0; b_if.read_enable = 0; b_if.address = '0; b_if.data_in = '0; b_if.byte_en = '0;
    endtask

    // One cycle on instance A; expectations follow directly from the request kind.
    task automatic op_a(input string tag, input logic we, input logic re, input logic [4:0] addr,
                        input logic [7:0] din, input logic be);
        logic exp_dv;
        logic exp_err;
        a_if.write_enable = we; a_if.read_enable = re; a_if.address = addr;
        a_if.data_in = din; a_if.byte_en = be;
        @(posedge clk); #1;
        exp_dv = 0; exp_err = 0;
        if (we && re) exp_err = 1;
        else if (we) begin if (be) mdl_a[addr] = din; end
        else if (re) begin exp_q_a = mdl_a[addr]; exp_dv = 1; end
        $display("A %s we=%0d re=%0d addr=%0d din=%h be=%0d -> q=%h dv=%0d err=%0d",
                 tag, we, re, addr, din, be, a_if.data_out, a_if.data_valid, a_if.err);
        chk({tag, "_q"},    a_if.data_out,   exp_q_a);
        chk({tag, "_dv"},   a_if.data_valid, exp_dv);
        chk({tag, "_err"},  a_if.err,        exp_err);
        chk({tag, "_busy"}, a_if.busy,       1'b0);
    endtask

    task automatic op_b(input string tag, input logic we, input logic re, input logic [2:0] addr,
                        input logic [15:0] din, input logic [1:0] be);
        logic exp_dv;
        logic exp_err;
        b_if.write_enable = we; b_if.read_enable = re; b_if.address = addr;
        b_if.data_in = din; b_if.byte_en = be;
        @(posedge clk); #1;
        exp_dv = 0; exp_err = 0;
        if (we && re) exp_err = 1;
        else if (we) begin
            for (int k = 0; k < 2; k++)
                if (be[k]) mdl_b[addr][8*k +: 8] = din[8*k +: 8];
        end
        else if (re) begin exp_q_b = mdl_b[addr]; exp_dv = 1; end
        $display("B %s we=%0d re=%0d addr=%0d din=%h be=%b -> q=%h dv=%0d err=%0d",
                 tag, we, re, addr, din, be, b_if.data_out, b_if.data_valid, b_if.err);
        chk({tag, "_q"},   b_if.data_out,   exp_q_b);
        chk({tag, "_dv"},  b_if.data_valid, exp_dv);
        chk({tag, "_err"}, b_if.err,        exp_err);
    endtask

    // Counts edges after reset release until busy drops; random requests on A
    // meanwhile must be ignored entirely.
    task automatic wait_clear(input string tag);
        int n;
        int nb;
        n = 0; nb = 0;
        do begin
            a_if.write_enable = 1'($urandom_range(0, 1));
            a_if.read_enable  = 1'($urandom_range(0, 1));
            a_if.address      = 5'($urandom_range(0, 31));
            a_if.data_in      = 8'($urandom);
            a_if.byte_en      = 1'b1;
            @(posedge clk); #1;
            n++;
            if (nb == 0 && b_if.busy === 1'b0) nb = n;
            chk({tag, "_clr_q"},   a_if.data_out,   8'h00);
            chk({tag, "_clr_dv"},  a_if.data_valid, 1'b0);
            chk({tag, "_clr_err"}, a_if.err,        1'b0);
        end while (a_if.busy === 1'b1 && n < 200);
        idle_inputs();
        $display("%s clear: A busy cycles=%0d B busy cycles=%0d", tag, n, nb);
        chk({tag, "_busy_cycles_a"}, n,  32);
        chk({tag, "_busy_cycles_b"}, nb, 8);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        idle_inputs();
        reset_models();
        #2;
        chk("rst_q",    a_if.data_out,   8'h00);
        chk("rst_dv",   a_if.data_valid, 1'b0);
        chk("rst_err",  a_if.err,        1'b0);
        chk("rst_busy", a_if.busy,       1'b1);
        chk("rst_busy_b", b_if.busy,     1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        wait_clear("init");

        for (int i = 0; i < 32; i++) op_a("rd_all", 0, 1, 5'(i), 8'h00, 1'b0);

        op_a("wr3",   1, 0, 5'd3, 8'hA5, 1'b1);
        op_a("rd3",   0, 1, 5'd3, 8'h00, 1'b0);
        op_a("wr7",   1, 0, 5'd7, 8'h3C, 1'b1);
        op_a("both7", 1, 1, 5'd7, 8'hFF, 1'b1);
        op_a("idle",  0, 0, 5'd7, 8'h00, 1'b0);
        op_a("rd7",   0, 1, 5'd7, 8'h00, 1'b0);
        op_a("wr_nobe", 1, 0, 5'd7, 8'h11, 1'b0);
        op_a("rd7b",  0, 1, 5'd7, 8'h00, 1'b0);

        for (int i = 0; i < 200; i++) begin
            int r;
            r = $urandom_range(0, 9);
            op_a("rnd", (r == 1) || (r >= 2 && r <= 5), (r == 1) || (r >= 6),
                 5'($urandom_range(0, 31)), 8'($urandom), 1'($urandom_range(0, 1)));
        end
        idle_inputs();

        op_b("b_rd_init", 0, 1, 3'd2, 16'h0000, 2'b00);
        op_b("b_wr_full", 1, 0, 3'd2, 16'h1234, 2'b11);
        op_b("b_wr_hi",   1, 0, 3'd2, 16'hABCD, 2'b10);
        op_b("b_rd2",     0, 1, 3'd2, 16'h0000, 2'b00);
        op_b("b_both",    1, 1, 3'd2, 16'h5555, 2'b11);
        for (int i = 0; i < 60; i++) begin
            int r;
            r = $urandom_range(0, 9);
            op_b("b_rnd", (r == 1) || (r >= 2 && r <= 5), (r == 1) || (r >= 6),
                 3'($urandom_range(0, 7)), 16'($urandom), 2'($urandom_range(0, 3)));
        end
        idle_inputs();

        op_a("wr5", 1, 0, 5'd5, 8'h77, 1'b1);
        op_a("rd5", 0, 1, 5'd5, 8'h00, 1'b0);
        idle_inputs();
        // Reset between clock edges must clear outputs without waiting for clk.
        #2 reset = 1'b1;
        #1;
        chk("arst_q",    a_if.data_out,   8'h00);
        chk("arst_dv",   a_if.data_valid, 1'b0);
        chk("arst_busy", a_if.busy,       1'b1);
        @(posedge clk); #1;
        reset = 1'b0;
        reset_models();
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("mid_busy", a_if.busy, 1'b1);
        end
        #2 reset = 1'b1;
        #1;
        chk("abort_busy", a_if.busy, 1'b1);
        @(posedge clk); #1;
        reset = 1'b0;
        wait_clear("abort");
        op_a("rd5_after", 0, 1, 5'd5, 8'h00, 1'b0);
        op_a("rd7_after", 0, 1, 5'd7, 8'h00, 1'b0);
        idle_inputs();
        op_b("b_rd2_after", 0, 1, 3'd2, 16'h0000, 2'b00);
        idle_inputs();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ram_sp_param.md
RAM_SP_PARAM -- requirements
Module: ram_sp_param

Interface
REQ-001 Parameters, one per line: name, default, meaning; ports, one per line: name, direction, width, meaning.
REQ-002 DATA_W, 8, data width in bits; SHALL be a multiple of 8.
REQ-003 ADDR_W, 5, address width; DEPTH = 2**ADDR_W words.
REQ-004 INIT_VAL, 0, word value written to every location by the post-reset clear sequence.
REQ-005 One clock; reset is asynchronous and active-high.
REQ-006 clk  input  1  clock; all state changes on its rising edge except reset.
REQ-007 reset  input  1  asynchronous, active-high.
REQ-008 write_enable  input  1  write request.
REQ-009 read_enable  input  1  read request.
REQ-010 address  input  ADDR_W  word address for read or write.
REQ-011 data_in  input  DATA_W  write data.
REQ-012 byte_en  input  DATA_W/8  per-byte write mask; bit k covers data bits [8k+7:8k].
REQ-013 data_out  output  DATA_W  registered read data.
REQ-014 data_valid  output  1  one-cycle pulse: data_out updated by a read.
REQ-015 busy  output  1  high while in reset or clear sequence; requests are ignored.
REQ-016 err  output  1  one-cycle pulse: read and write requested together.

Function
REQ-017 FSM states SHALL be CLEAR and IDLE only; reset forces CLEAR with clear counter = 0.
REQ-018 In CLEAR, each cycle SHALL write INIT_VAL to mem[counter] and increment the counter; the transition to IDLE SHALL occur on the edge that writes location DEPTH-1. Clear therefore takes exactly DEPTH cycles after reset release.
REQ-019 busy SHALL be 1 in CLEAR and 0 in IDLE.
REQ-020 In CLEAR, write_enable, read_enable, address, data_in and byte_en SHALL be ignored: no write, data_valid = 0, err = 0.
REQ-021 In IDLE, write_enable=1 with read_enable=0 SHALL update only the bytes of mem[address] whose byte_en bit is 1; other bytes retain their value; data_out is unchanged; data_valid = 0.
REQ-022 In IDLE, read_enable=1 with write_enable=0 SHALL load data_out with mem[address] at that edge and assert data_valid for the following cycle only (1-cycle latency).
REQ-023 data_out SHALL hold its last value when no read occurs.
REQ-024 In IDLE, both enables = 1 SHALL perform no access; err = 1 for the following cycle only; memory and data_out are unchanged; data_valid = 0.
REQ-025 Back-to-back operations SHALL be accepted every cycle; a read issued on the cycle after a write to the same address SHALL return the newly written data.
REQ-026 Address wrap is not applicable: every ADDR_W value maps to a valid word; there is no out-of-range case.

Reset
REQ-027 Reset assertion SHALL immediately force data_out = 0, data_valid = 0, err = 0, busy = 1 and state = CLEAR with counter = 0, independent of clk.
REQ-028 Reset asserted mid-CLEAR or mid-access SHALL abort that sequence; after release, the clear restarts from address 0 and all previous contents become INIT_VAL.

Verification
REQ-029 Default parameters: release reset -> busy = 1 for exactly 32 cycles; then reading addresses 0..31 -> data_out = 0x00, one data_valid pulse per read.
REQ-030 Default parameters: write 0xA5 to address 3 with byte_en = 1; next cycle, read address 3 -> data_out = 0xA5 with data_valid = 1 one cycle after the read edge.
REQ-031 Both enables at address 7 after mem[7] = 0x3C -> err pulses for 1 cycle, data_valid = 0; a later read of address 7 -> 0x3C.
REQ-032 DATA_W = 16: write 0x1234 with byte_en = 2'b11, then 0xABCD with byte_en = 2'b10; read -> 0xAB34.
REQ-033 Reset pulsed when the clear counter = 10, after mem[5] was written with 0x77 -> busy stays 1 and the counter restarts at 0; busy falls 32 cycles after release; read address 5 -> 0x00.
REQ-034 Read request while busy = 1 -> no data_valid, no err, data_out unchanged.
